// File: rtl/alu_operand_stack_if.sv
// Sequencer-facing bundle for the ALU operand stack: op handshake, PUSH data,
// ALU result/zero inputs, and the stack status outputs.
interface alu_operand_stack_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             op_valid;
    logic [2:0]       op;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] alu_res;
    logic             alu_zero;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] tos;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             zero_flag;
    logic             overflow;
    logic             underflow;
    logic             op_done;

    modport master (
        output op_valid, op, din, alu_res, alu_zero,
        input  alu_a, alu_b, tos, count, empty, full,
        input  zero_flag, overflow, underflow, op_done
    );

    modport slave (
        input  op_valid, op, din, alu_res, alu_zero,
        output alu_a, alu_b, tos, count, empty, full,
        output zero_flag, overflow, underflow, op_done
    );
endinterface

// File: rtl/alu_operand_stack.sv
// LIFO operand stack feeding an external ALU: NOS/TOS drive alu_a/alu_b, and
// EXEC collapses the top two entries into the ALU result, one op per cycle.
module alu_operand_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_operand_stack_if.slave   bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        OP_NOP    = 3'd0,
        OP_PUSH   = 3'd1,
        OP_POP    = 3'd2,
        OP_DUP    = 3'd3,
        OP_SWAP   = 3'd4,
        OP_EXEC   = 3'd5,
        OP_OVER   = 3'd6,
        OP_CLRERR = 3'd7
    } op_e;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_next;
    logic             zero_flag_q;
    logic             overflow_q;
    logic             underflow_q;
    logic             op_done_q;

    logic [AW-1:0]    top_idx;
    logic [AW-1:0]    nos_idx;
    logic [AW-1:0]    free_idx;
    logic             has_one;
    logic             has_two;
    logic             is_full;
    logic [WIDTH-1:0] tos_val;
    logic [WIDTH-1:0] nos_val;
    op_e              op_cmd;

    logic             need_one;
    logic             need_two;
    logic             need_slot;
    logic             short_fault;
    logic             room_fault;
    logic             op_ok;
    logic             wr_en;
    logic [AW-1:0]    wr_idx;
    logic [WIDTH-1:0] wr_data;
    logic             swap_en;
    logic             zf_load;

    // Truncating to AW bits is safe: each index is used only when count makes it in range.
    assign top_idx  = AW'(count_q - CW'(1));
    assign nos_idx  = AW'(count_q - CW'(2));
    assign free_idx = AW'(count_q);
    assign has_one  = (count_q >= CW'(1));
    assign has_two  = (count_q >= CW'(2));
    assign is_full  = (count_q == CW'(DEPTH));
    assign tos_val  = has_one ? mem[top_idx] : '0;
    assign nos_val  = has_two ? mem[nos_idx] : '0;
    assign op_cmd   = op_e'(bus.op);

    always_comb begin
        need_one   = 1'b0;
        need_two   = 1'b0;
        need_slot  = 1'b0;
        count_next = count_q;
        wr_en      = 1'b0;
        wr_idx     = free_idx;
        wr_data    = bus.din;
        swap_en    = 1'b0;
        zf_load    = 1'b0;

        case (op_cmd)
            OP_PUSH: need_slot = 1'b1;
            OP_POP:  need_one  = 1'b1;
            OP_DUP:  begin need_one = 1'b1; need_slot = 1'b1; end
            OP_SWAP: need_two  = 1'b1;
            OP_EXEC: need_two  = 1'b1;
            OP_OVER: begin need_two = 1'b1; need_slot = 1'b1; end
            default: ;
        endcase

        // A missing entry takes precedence, so DUP/OVER on a short stack never report overflow.
        short_fault = (need_one && !has_one) || (need_two && !has_two);
        room_fault  = !short_fault && need_slot && is_full;
        op_ok       = bus.op_valid && !short_fault && !room_fault;

        if (op_ok) begin
            case (op_cmd)
                OP_PUSH: begin
                    wr_en      = 1'b1;
                    count_next = count_q + CW'(1);
                end
                OP_POP:  count_next = count_q - CW'(1);
                OP_DUP: begin
                    wr_en      = 1'b1;
                    wr_data    = tos_val;
                    count_next = count_q + CW'(1);
                end
                OP_SWAP: swap_en = 1'b1;
                OP_EXEC: begin
                    wr_en      = 1'b1;
                    wr_idx     = nos_idx;
                    wr_data    = bus.alu_res;
                    zf_load    = 1'b1;
                    count_next = count_q - CW'(1);
                end
                OP_OVER: begin
                    wr_en      = 1'b1;
                    wr_data    = nos_val;
                    count_next = count_q + CW'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
        if (swap_en) begin
            mem[top_idx] <= nos_val;
            mem[nos_idx] <= tos_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= '0;
            zero_flag_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            op_done_q   <= 1'b0;
        end else begin
            op_done_q <= bus.op_valid;
            count_q   <= count_next;
            if (zf_load) begin
                zero_flag_q <= bus.alu_zero;
            end
            if (bus.op_valid && op_cmd == OP_CLRERR) begin
                overflow_q  <= 1'b0;
                underflow_q <= 1'b0;
            end else if (bus.op_valid && short_fault) begin
                underflow_q <= 1'b1;
            end else if (bus.op_valid && room_fault) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign bus.alu_a     = nos_val;
    assign bus.alu_b     = tos_val;
    assign bus.tos       = tos_val;
    assign bus.count     = count_q;
    assign bus.empty     = (count_q == '0);
    assign bus.full      = is_full;
    assign bus.zero_flag = zero_flag_q;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
    assign bus.op_done   = op_done_q;
endmodule
